serial_add_sub: RTL and testbench
=================================

SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL use one clock and a synchronous, active-high reset; ports are listed clock and reset first.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; synchronous to clk, active-high.
REQ-005 start  input  1  request; a 1-cycle pulse launches an operation.
REQ-006 op  input  1  operation select: 0 = add (a+b), 1 = subtract (a-b).
REQ-007 a  input  WIDTH  first operand, unsigned or two's complement.
REQ-008 b  input  WIDTH  second operand.
REQ-009 busy  output  1  high while bits are being processed.
REQ-010 done  output  1  1-cycle pulse; result, cout and ovf are valid.
REQ-011 result  output  WIDTH  sum or difference.
REQ-012 cout  output  1  final carry (add) or final borrow (sub).
REQ-013 ovf  output  1  two's-complement signed overflow.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 IDLE/DONE with start=1 at an edge: latch a, b and op; clear the carry/borrow flop and the bit counter; go to RUN.
REQ-016 RUN: each edge processes one bit, LSB first, through the 1-bit cell, with carry/borrow-in taken from the flop.
REQ-017 RUN edge effects: shift the result bit in at the MSB of the result shift register; update the flop; increment the counter.
REQ-018 SHALL leave RUN after exactly WIDTH processing edges and enter DONE.
REQ-019 Latency: start is sampled at edge k; done is high in the cycle following edge k+WIDTH.
REQ-020 DONE lasts one cycle; without start it returns to IDLE.
REQ-021 busy = 1 in RUN only; done = 1 in DONE only.
REQ-022 start while in RUN SHALL be ignored; operands and op are unaffected.
REQ-023 start in DONE SHALL be accepted, giving back-to-back operations with no idle cycle.
REQ-024 Operand or op changes after the start edge SHALL have no effect on the operation in flight.
REQ-025 Add result is (a+b) mod 2^WIDTH; cout = carry out of the MSB.
REQ-026 Subtract result is (a-b) mod 2^WIDTH; cout = 1 iff a < b unsigned.
REQ-027 ovf, add: a[MSB]==b[MSB] and result[MSB]!=a[MSB]. ovf, sub: a[MSB]!=b[MSB] and result[MSB]!=a[MSB]. Both use the latched operands.
REQ-028 result, cout and ovf SHALL hold their values from DONE until the next start is accepted.
REQ-029 result is not guaranteed valid while busy=1.

Reset
REQ-030 With rst=1 at an edge: state = IDLE; busy, done, result, cout, ovf, counter, carry flop and latched operands all 0.
REQ-031 rst SHALL take priority over start.
REQ-032 Reset during RUN SHALL abort the operation; no done pulse is generated for it.

Structure
REQ-033 A shared package/header SHALL hold the FSM state encodings and the op constants (OP_ADD = 0, OP_SUB = 1).
REQ-034 SHALL instantiate one combinational sub-module, serial_bit_cell: inputs a, b, cin, op; outputs s, cout; full-adder or full-subtractor per op.
REQ-035 Counter width SHALL be $clog2(WIDTH+1) bits.

Verification (WIDTH = 8)
REQ-036 add 8'hFF + 8'h01 -> done 8 edges after the start edge; result 8'h00, cout 1, ovf 0.
REQ-037 add 8'h7F + 8'h01 -> result 8'h80, cout 0, ovf 1. Sub 8'h80 - 8'h01 -> result 8'h7F, cout 0, ovf 1.
REQ-038 sub 8'h03 - 8'h05 -> result 8'hFE, cout 1, ovf 0. Sub 8'h05 - 8'h03 -> result 8'h02, cout 0, ovf 0.
REQ-039 start with 8'h10 + 8'h20, then start with 8'hFF - 8'h01 pulsed at RUN edge 3 -> single done; result 8'h30; busy high for exactly 8 cycles.
REQ-040 rst asserted at RUN edge 4 -> no done; all outputs 0 the cycle after. A new start then yields a correct result.
REQ-041 Back-to-back: start held through DONE with 8'h01 + 8'h01 -> second done exactly 9 cycles after the first; result 8'h02.
REQ-042 Random: 1000 random a, b, op vs reference model -> every result, cout and ovf match.

Source files
------------

// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
//   state_t : FSM state encoding (IDLE, RUN, DONE)
//   OP_ADD / OP_SUB : operation select values for the op input
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_sub_bit_cell.sv
// One-bit arithmetic cell: full adder when op = OP_ADD, full subtractor
// (a - b - borrow_in) when op = OP_SUB.
//   a, b : operand bits
//   cin  : carry-in (add) or borrow-in (sub)
//   op   : operation select
//   s    : sum / difference bit
//   cout : carry-out (add) or borrow-out (sub)
module serial_bit_cell
  import serial_add_sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic op,
  output logic s,
  output logic cout
);

  always_comb begin
    s = a ^ b ^ cin;
    if (op == OP_ADD) begin
      cout = (a & b) | (cin & (a ^ b));
    end else begin
      // Borrow when b exceeds a, or when they are equal and a borrow ripples in.
      cout = (~a & b) | (cin & ~(a ^ b));
    end
  end

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor. A start pulse latches the operands and op,
// then one bit per clock is processed LSB first through serial_bit_cell.
// After WIDTH processing cycles the result is presented with a done pulse
// and held until the next accepted start.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   start  : launch request (accepted in IDLE or DONE, ignored in RUN)
//   op     : 0 = add, 1 = subtract
//   a, b   : operands
//   busy   : high while bits are being processed
//   done   : one-cycle pulse when result/cout/ovf are valid
//   result : sum or difference mod 2^WIDTH
//   cout   : final carry (add) or final borrow (sub)
//   ovf    : two's-complement signed overflow
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             last_bit;

  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             op_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             a_msb;
  logic             b_msb;
  logic [WIDTH-1:0] res_sh;
  logic             cout_q;
  logic             ovf_q;

  logic             cell_s;
  logic             cell_c;

  // Signed overflow from the latched operand sign bits and the final result bit.
  function automatic logic ovf_calc(input logic o, input logic am,
                                    input logic bm, input logic rm);
    if (o == OP_ADD) begin
      return (am == bm) && (rm != am);
    end else begin
      return (am != bm) && (rm != am);
    end
  endfunction

  serial_bit_cell u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .op   (op_q),
    .s    (cell_s),
    .cout (cell_c)
  );

  assign last_bit = (cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, shift one bit per RUN cycle, capture flags on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      carry  <= 1'b0;
      op_q   <= OP_ADD;
      a_sh   <= '0;
      b_sh   <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      res_sh <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      carry <= 1'b0;
      op_q  <= op;
      a_sh  <= a;
      b_sh  <= b;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (state == RUN) begin
      res_sh <= {cell_s, res_sh[WIDTH-1:1]};
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      carry  <= cell_c;
      cnt    <= cnt + CNT_W'(1);
      if (last_bit) begin
        cout_q <= cell_c;
        ovf_q  <= ovf_calc(op_q, a_msb, b_msb, cell_s);
      end
    end
  end

  assign result = res_sh;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed and random checks of serial_add_sub at WIDTH = 8.
module tb_serial_add_sub;

  logic       clk;
  logic       rst;
  logic       start;
  logic       op;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       cout;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  serial_add_sub #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic o, input logic [7:0] x, input logic [7:0] y,
                                output logic [7:0] r, output logic c, output logic v);
    logic [8:0] t;
    if (o == 1'b0) begin
      t = {1'b0, x} + {1'b0, y};
      r = t[7:0];
      c = t[8];
      v = (x[7] == y[7]) && (r[7] != x[7]);
    end else begin
      r = x - y;
      c = (x < y);
      v = (x[7] != y[7]) && (r[7] != x[7]);
    end
  endfunction

  // Launch one operation, scramble inputs after the start edge, then check
  // latency and the flags against the supplied expectations.
  task automatic run_op(input string tag, input logic o, input logic [7:0] x,
                        input logic [7:0] y, input logic [7:0] er,
                        input logic ec, input logic eo);
    int n;
    a = x; b = y; op = o; start = 1'b1;
    tick();
    start = 1'b0; a = ~x; b = ~y; op = ~o;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'd8);
    chk({tag, " result"}, 32'(result), 32'(er));
    chk({tag, " cout"}, 32'(cout), 32'(ec));
    chk({tag, " ovf"}, 32'(ovf), 32'(eo));
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int n;
    logic [7:0] res_seen;
    logic seen;
    logic [7:0] x, y, er;
    logic o, ec, eo;

    rst = 1'b1; start = 1'b0; op = 1'b0; a = 8'h00; b = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", 32'(result), 32'd0);
    chk("reset cout", 32'(cout), 32'd0);
    chk("reset ovf", 32'(ovf), 32'd0);

    // Directed arithmetic boundaries.
    run_op("add ff+01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run_op("add 7f+01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    run_op("sub 80-01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op("sub 03-05", 1'b1, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    run_op("sub 05-03", 1'b1, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);

    // Outputs hold after done while idle.
    repeat (3) tick();
    chk("hold result", 32'(result), 32'h02);
    chk("hold done", 32'(done), 32'd0);
    chk("hold busy", 32'(busy), 32'd0);

    // Start during RUN is ignored.
    a = 8'h10; b = 8'h20; op = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    busy_cnt = 0; done_cnt = 0; res_seen = 8'h00;
    for (int i = 0; i < 14; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        res_seen = result;
      end
      if (i == 2) begin
        start = 1'b1; a = 8'hFF; b = 8'h01; op = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    chk("ignore busy cycles", 32'(busy_cnt), 32'd8);
    chk("ignore done count", 32'(done_cnt), 32'd1);
    chk("ignore result", 32'(res_seen), 32'h30);

    // Reset mid-operation aborts it.
    a = 8'hFF; b = 8'hFF; op = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort result", 32'(result), 32'd0);
    chk("abort cout", 32'(cout), 32'd0);
    chk("abort ovf", 32'(ovf), 32'd0);
    seen = 1'b0;
    repeat (12) begin
      if (done) seen = 1'b1;
      tick();
    end
    chk("abort no done", 32'(seen), 32'd0);
    run_op("recover add", 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0);

    // Back-to-back with start held high.
    a = 8'h01; b = 8'h01; op = 1'b0; start = 1'b1;
    tick();
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk("b2b first latency", 32'(n), 32'd8);
    n = 0;
    tick();
    n++;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    start = 1'b0;
    chk("b2b spacing", 32'(n), 32'd9);
    chk("b2b result", 32'(result), 32'h02);
    repeat (2) tick();
    chk("b2b idle busy", 32'(busy), 32'd0);

    // Random operands against the reference model.
    for (int k = 0; k < 1000; k++) begin
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      o = 1'($urandom_range(0, 1));
      model(o, x, y, er, ec, eo);
      run_op("random", o, x, y, er, ec, eo);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
